// File: rtl/hex_keypad_scan.sv
// hex_keypad_scan
//
// Scans a 4x4 hex matrix keypad and turns key presses into debounced hex
// codes. One column is pulled low at a time, and the four pulled-up row lines
// are read back. Each full pass over the four columns (one frame) is reduced
// to NONE, SINGLE(code) or MULTI. A small state machine debounces presses
// and releases over whole frames.
//
// Parameters:
//   SCAN_DIV  - CLK cycles each column is driven (4..255)
//   DEBOUNCE  - identical consecutive frames needed to accept a press or a
//               release (1..15)
//
// Ports:
//   CLK        - system clock, rising edge
//   RST_N      - asynchronous active-low reset
//   ROW[3:0]   - keypad rows, active-low, asynchronous to CLK
//   COL[3:0]   - keypad column drive, active-low, exactly one bit low
//   KEY[3:0]   - last accepted key, {row_index, col_index}
//   KEY_VALID  - one-cycle pulse when a new press is accepted
//   KEY_DOWN   - high while the accepted key is considered held

module hex_keypad_scan #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_DOWN
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } frame_res_t;

    localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
    localparam logic [4:0] DEB_LIMIT = 5'(DEBOUNCE);
    localparam bit         INSTANT   = (DEBOUNCE == 1);

    logic [3:0] row_meta;
    logic [3:0] row_sync;
    logic [7:0] slot_cnt;
    logic [1:0] col_idx;

    logic [1:0] acc_hits;
    logic [3:0] acc_code;

    logic       sample_now;
    logic       frame_end;
    logic [3:0] row_low;
    logic [2:0] sample_cnt;
    logic [1:0] sample_hits;
    logic [1:0] row_pos;
    logic [2:0] hit_sum;
    logic [1:0] merged_hits;
    logic [3:0] merged_code;
    frame_res_t frame_res;

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [3:0] cand;
    logic [3:0] cand_n;
    logic [3:0] key_n;
    logic       valid_n;
    logic       down_n;
    logic [4:0] cnt_inc;
    logic       cnt_reached;
    logic [3:0] cnt_sat;

    // Two-flop synchronizer: ROW comes straight from the pins and must not
    // reach any decision logic before it has settled into the CLK domain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta <= 4'h0;
            row_sync <= 4'h0;
        end else begin
            row_meta <= ROW;
            row_sync <= row_meta;
        end
    end

    assign sample_now = (slot_cnt == SLOT_LAST);
    assign frame_end  = sample_now && (col_idx == 2'd3);

    // Column scan timing. The column is sampled at the very end of its slot so
    // the synchronizer has had SCAN_DIV-1 cycles to see the new column's rows.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_cnt <= 8'h00;
            col_idx  <= 2'd0;
            COL      <= 4'b1110;
        end else if (sample_now) begin
            slot_cnt <= 8'h00;
            col_idx  <= col_idx + 2'd1;
            COL      <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            slot_cnt <= slot_cnt + 8'h01;
        end
    end

    // Reduce the current column's sample to a hit count (saturated at 2) and
    // fold it into the frame accumulator. The code is only meaningful when
    // the whole frame ends up with exactly one hit.
    always_comb begin
        row_low    = ~row_sync;
        sample_cnt = {2'b00, row_low[0]} + {2'b00, row_low[1]}
                   + {2'b00, row_low[2]} + {2'b00, row_low[3]};
        sample_hits = (sample_cnt >= 3'd2) ? 2'd2 : sample_cnt[1:0];
        row_pos = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (row_low[r]) begin
                row_pos = 2'(r);
            end
        end
        hit_sum     = {1'b0, acc_hits} + {1'b0, sample_hits};
        merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_code = (acc_hits == 2'd0) ? {row_pos, col_idx} : acc_code;
        case (merged_hits)
            2'd0:    frame_res = RES_NONE;
            2'd1:    frame_res = RES_SINGLE;
            default: frame_res = RES_MULTI;
        endcase
    end

    // Frame accumulator. At frame end the merged result goes to the FSM and
    // the accumulator starts the next frame empty.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
        end else if (frame_end) begin
            acc_hits <= 2'd0;
            acc_code <= 4'h0;
        end else if (sample_now) begin
            acc_hits <= merged_hits;
            acc_code <= merged_code;
        end
    end

    // Debounce state register and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= 4'h0;
            cand      <= 4'h0;
            KEY       <= 4'h0;
            KEY_VALID <= 1'b0;
            KEY_DOWN  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            KEY       <= key_n;
            KEY_VALID <= valid_n;
            KEY_DOWN  <= down_n;
        end
    end

    assign cnt_inc     = {1'b0, cnt} + 5'd1;
    assign cnt_reached = (cnt_inc >= DEB_LIMIT);
    assign cnt_sat     = cnt_reached ? DEB_LIMIT[3:0] : cnt_inc[3:0];

    // Debounce decisions, taken only once per frame. HELD ignores any new
    // codes, so rollover keys cannot fire until everything has been released.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        key_n   = KEY;
        valid_n = 1'b0;
        down_n  = KEY_DOWN;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_res == RES_SINGLE) begin
                        cand_n = merged_code;
                        if (INSTANT) begin
                            key_n   = merged_code;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                            cnt_n   = 4'h0;
                            state_n = HELD;
                        end else begin
                            cnt_n   = 4'h1;
                            state_n = DEB_PRESS;
                        end
                    end else begin
                        cnt_n = 4'h0;
                    end
                end
                DEB_PRESS: begin
                    if (frame_res == RES_SINGLE && merged_code == cand) begin
                        if (cnt_reached) begin
                            key_n   = cand;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                            cnt_n   = 4'h0;
                            state_n = HELD;
                        end else begin
                            cnt_n = cnt_sat;
                        end
                    end else if (frame_res == RES_SINGLE) begin
                        cand_n = merged_code;
                        cnt_n  = 4'h1;
                    end else begin
                        cnt_n   = 4'h0;
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (frame_res == RES_NONE) begin
                        if (INSTANT) begin
                            down_n  = 1'b0;
                            cnt_n   = 4'h0;
                            state_n = IDLE;
                        end else begin
                            cnt_n   = 4'h1;
                            state_n = DEB_RELEASE;
                        end
                    end
                end
                DEB_RELEASE: begin
                    if (frame_res == RES_NONE) begin
                        if (cnt_reached) begin
                            down_n  = 1'b0;
                            cnt_n   = 4'h0;
                            state_n = IDLE;
                        end else begin
                            cnt_n = cnt_sat;
                        end
                    end else begin
                        cnt_n   = 4'h0;
                        state_n = HELD;
                    end
                end
                default: begin
                    cnt_n   = 4'h0;
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_keypad_scan.sv
// tb_hex_keypad_scan
//
// Directed bench for hex_keypad_scan with SCAN_DIV=4, DEBOUNCE=2. A behavioural
// keypad model drives ROW from COL and a 16-bit mask of pressed keys (bit
// index == key code). The stimulus process pushes each expected KEY_VALID
// event (code and cycle) into a queue; an independent monitor pops and checks
// on every KEY_VALID it observes. Frames are 16 cycles and are aligned to the
// reset release, so frame n ends at cycle 16*n.

module tb_hex_keypad_scan;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [3:0]  KEY;
    logic        KEY_VALID;
    logic        KEY_DOWN;

    logic [15:0] pressed;
    int          cyc;
    int          checks = 0;
    int          fails  = 0;

    typedef struct {
        logic [3:0] code;
        int         cycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monItem;

    hex_keypad_scan #(
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ROW      (ROW),
        .COL      (COL),
        .KEY      (KEY),
        .KEY_VALID(KEY_VALID),
        .KEY_DOWN (KEY_DOWN)
    );

    always #5 CLK = ~CLK;

    // Keypad matrix: a pressed key connects its row to its column, so the row
    // is pulled low while that column is driven low.
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !COL[c]) begin
                    ROW[r] = 1'b0;
                end
            end
        end
    end

    // Cycles since reset release.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        pressed = keys;
    endtask

    task automatic expectValid(input logic [3:0] code, input int at);
        exp_t e;
        e.code  = code;
        e.cycle = at;
        expQ.push_back(e);
    endtask

    task automatic waitCycle(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            fails++;
            $display("[TB] FAIL wait_cycle: got %0d expected %0d", cyc, n);
        end
    endtask

    // Scoreboard monitor: every KEY_VALID must match the next queued event.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && KEY_VALID === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_key_valid", 32'd1, 32'd0);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("valid_key", {28'h0, KEY}, {28'h0, monItem.code});
                checkOutput("valid_cycle", cyc, monItem.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] expCol;
        RST_N = 1'b0;
        applyStimulus(16'h0200);
        repeat (3) @(negedge CLK);
        checkOutput("reset_col", {28'h0, COL}, 32'hE);
        checkOutput("reset_key", {28'h0, KEY}, 32'h0);
        checkOutput("reset_valid", {31'h0, KEY_VALID}, 32'h0);
        checkOutput("reset_down", {31'h0, KEY_DOWN}, 32'h0);

        // Test 1: key 9 held from reset release.
        $display("[TB] test 1: press 9 from reset");
        expectValid(4'h9, 32);
        RST_N = 1'b1;
        for (int k = 0; k < 16; k++) begin
            waitCycle(k);
            expCol = ~(4'b0001 << ((k / 4) % 4));
            checkOutput("col_scan", {28'h0, COL}, {28'h0, expCol});
        end
        waitCycle(16);
        checkOutput("t1_down_frame1", {31'h0, KEY_DOWN}, 32'h0);
        waitCycle(32);
        checkOutput("t1_key", {28'h0, KEY}, 32'h9);
        checkOutput("t1_down", {31'h0, KEY_DOWN}, 32'h1);

        // Test 2: release for two frames.
        $display("[TB] test 2: release 9");
        applyStimulus(16'h0000);
        waitCycle(48);
        checkOutput("t2_down_still", {31'h0, KEY_DOWN}, 32'h1);
        waitCycle(64);
        checkOutput("t2_down_clear", {31'h0, KEY_DOWN}, 32'h0);
        checkOutput("t2_key_kept", {28'h0, KEY}, 32'h9);

        // Test 3: bouncy key 3.
        $display("[TB] test 3: bounce on key 3");
        applyStimulus(16'h0008);
        waitCycle(80);
        applyStimulus(16'h0000);
        checkOutput("t3_down_frame1", {31'h0, KEY_DOWN}, 32'h0);
        waitCycle(96);
        applyStimulus(16'h0008);
        expectValid(4'h3, 128);
        waitCycle(128);
        checkOutput("t3_key", {28'h0, KEY}, 32'h3);
        checkOutput("t3_down", {31'h0, KEY_DOWN}, 32'h1);
        applyStimulus(16'h0000);
        waitCycle(160);
        checkOutput("t3_down_clear", {31'h0, KEY_DOWN}, 32'h0);

        // Test 4: keys 0 and 5 together, then 5 released.
        $display("[TB] test 4: two keys, then one");
        applyStimulus(16'h0021);
        waitCycle(240);
        checkOutput("t4_multi_down", {31'h0, KEY_DOWN}, 32'h0);
        checkOutput("t4_multi_key", {28'h0, KEY}, 32'h3);
        applyStimulus(16'h0001);
        expectValid(4'h0, 272);
        waitCycle(272);
        checkOutput("t4_key", {28'h0, KEY}, 32'h0);
        checkOutput("t4_down", {31'h0, KEY_DOWN}, 32'h1);
        applyStimulus(16'h0000);
        waitCycle(304);
        checkOutput("t4_down_clear", {31'h0, KEY_DOWN}, 32'h0);

        // Test 5: rollover A then F.
        $display("[TB] test 5: rollover");
        applyStimulus(16'h0400);
        expectValid(4'hA, 336);
        waitCycle(336);
        checkOutput("t5_key", {28'h0, KEY}, 32'hA);
        applyStimulus(16'h8400);
        waitCycle(352);
        applyStimulus(16'h8000);
        waitCycle(368);
        checkOutput("t5_roll_down", {31'h0, KEY_DOWN}, 32'h1);
        checkOutput("t5_roll_key", {28'h0, KEY}, 32'hA);
        applyStimulus(16'h0000);
        waitCycle(384);
        checkOutput("t5_down_still", {31'h0, KEY_DOWN}, 32'h1);
        waitCycle(400);
        checkOutput("t5_down_clear", {31'h0, KEY_DOWN}, 32'h0);
        checkOutput("t5_key_kept", {28'h0, KEY}, 32'hA);

        // Test 6: reset in the middle of press debouncing.
        $display("[TB] test 6: reset mid-debounce");
        applyStimulus(16'h0200);
        waitCycle(424);
        checkOutput("t6_pre_down", {31'h0, KEY_DOWN}, 32'h0);
        RST_N = 1'b0;
        #1;
        checkOutput("t6_rst_col", {28'h0, COL}, 32'hE);
        checkOutput("t6_rst_key", {28'h0, KEY}, 32'h0);
        checkOutput("t6_rst_valid", {31'h0, KEY_VALID}, 32'h0);
        checkOutput("t6_rst_down", {31'h0, KEY_DOWN}, 32'h0);
        repeat (3) @(negedge CLK);
        expectValid(4'h9, 32);
        RST_N = 1'b1;
        waitCycle(16);
        checkOutput("t6_down_frame1", {31'h0, KEY_DOWN}, 32'h0);
        checkOutput("t6_key_frame1", {28'h0, KEY}, 32'h0);
        waitCycle(32);
        checkOutput("t6_key", {28'h0, KEY}, 32'h9);
        checkOutput("t6_down", {31'h0, KEY_DOWN}, 32'h1);
        waitCycle(48);
        checkOutput("pending_events", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
